// File: rtl/byte_word_mem.sv
// Byte-addressed big-endian word memory with byte enables,
// registered read response, range errors and optional clear.
module byte_word_mem #(
  parameter int ADDR_WIDTH     = 11,
  parameter int MEM_DEPTH      = 2048,
  parameter int BYTES_PER_WORD = 2,
  parameter int CLEAR_ON_RESET = 1,
  localparam int WORD_WIDTH    = 8 * BYTES_PER_WORD
) (
  input  logic                      clock,
  input  logic                      nrst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wr,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [WORD_WIDTH-1:0]     req_wdata,
  input  logic [BYTES_PER_WORD-1:0] req_be,
  output logic                      rsp_valid,
  output logic [WORD_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int ROWS = MEM_DEPTH / BYTES_PER_WORD;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int AW1  = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] BPW_W = AW1'(BYTES_PER_WORD);
  localparam logic [AW1-1:0] SPAN  = AW1'(BYTES_PER_WORD - 1);
  localparam logic [AW1-1:0] LAST  = AW1'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP =
    ADDR_WIDTH'(BYTES_PER_WORD);
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST =
    ADDR_WIDTH'(MEM_DEPTH - BYTES_PER_WORD);

  if ((MEM_DEPTH % BYTES_PER_WORD) != 0 ||
      MEM_DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_param
    $error("byte_word_mem: illegal MEM_DEPTH");
  end

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_ptr;
  logic [RW-1:0]           clr_row;
  logic [AW1-1:0]          addr_x;
  logic [AW1-1:0]          lane;
  logic                    in_range;
  logic                    accept;
  logic                    wr_en;
  logic [AW1-1:0]          off   [BYTES_PER_WORD];
  logic [RW-1:0]           row   [BYTES_PER_WORD];
  int                      sh    [BYTES_PER_WORD];
  logic [7:0]              rbyte [BYTES_PER_WORD];
  logic [WORD_WIDTH-1:0]   rdata;

  assign addr_x   = {1'b0, req_addr};
  assign lane     = addr_x % BPW_W;
  assign in_range = (addr_x + SPAN) <= LAST;
  assign accept   = req_valid & req_ready;
  assign wr_en    = accept & req_wr & in_range;
  assign clr_row  = RW'(clr_ptr / STEP);

  // Bank b holds every byte whose address is b modulo the word size,
  // so each access touches each bank exactly once.
  for (genvar b = 0; b < BYTES_PER_WORD; b++) begin : g_bank
    logic [7:0] ram [ROWS];
    logic [7:0] wbyte;
    logic       be_bit;

    assign off[b]   = (AW1'(b) + BPW_W - lane) % BPW_W;
    assign row[b]   = RW'((addr_x + off[b]) / BPW_W);
    assign sh[b]    = 8 * int'(BPW_W - 1'b1 - off[b]);
    assign wbyte    = 8'(req_wdata >> sh[b]);
    assign be_bit   = 1'(req_be >> (BPW_W - 1'b1 - off[b]));
    assign rbyte[b] = ram[row[b]];

    always_ff @(posedge clock) begin
      if (state == CLEAR) begin
        ram[clr_row] <= '0;
      end else if (wr_en && be_bit) begin
        ram[row[b]] <= wbyte;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      rdata = rdata | (WORD_WIDTH'(rbyte[b]) << sh[b]);
    end
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      busy      <= (CLEAR_ON_RESET != 0);
      clr_ptr   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept & ~in_range;
      rsp_rdata <= (accept && !req_wr && in_range) ? rdata : '0;
      unique case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + STEP;
          if (clr_ptr == CLR_LAST) begin
            state     <= READY;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        READY: req_ready <= 1'b1;
        default: state <= READY;
      endcase
    end
  end

endmodule

// File: doc/byte_word_mem.md
Name: byte_word_mem

Overview:
Parametrised byte-addressed, big-endian word memory: the successor of the fixed 2048x8 / 16-bit-word node memory used by the routing/clustering datapath (flags, knownSinks, neighbor tables, HCM, counts). It adds configurable word width, per-byte write enables, a registered read with a valid/ready request handshake, and out-of-range error reporting. It also adds an optional post-reset clear sequencer that zeroes the array before it accepts requests.

Parameters:
ADDR_WIDTH, 11, byte-address width.
MEM_DEPTH, 2048, array size in bytes; must be <= 2**ADDR_WIDTH and a multiple of BYTES_PER_WORD.
BYTES_PER_WORD, 2, bytes per access word; WORD_WIDTH = 8*BYTES_PER_WORD.
CLEAR_ON_RESET, 1, 1 = zero all bytes after reset release; 0 = contents retained across reset.

Ports:
clock  in  1  sole clock, rising edge.
nrst  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_wr  in  1  1 = write, 0 = read.
req_addr  in  ADDR_WIDTH  byte address of the word's MSB byte; unaligned addresses allowed.
req_wdata  in  WORD_WIDTH  write data; [WORD_WIDTH-1:WORD_WIDTH-8] goes to req_addr.
req_be  in  BYTES_PER_WORD  byte enables; bit BYTES_PER_WORD-1 is the byte at req_addr, bit 0 is the byte at req_addr+BYTES_PER_WORD-1.
rsp_valid  out  1  one-cycle pulse: response for the request accepted on the previous edge.
rsp_rdata  out  WORD_WIDTH  read data, big-endian; 0 for writes and errors.
rsp_err  out  1  qualified by rsp_valid; 1 = access out of range.
busy  out  1  clear sequence in progress.

Behaviour:
- Reset is asynchronous, active-low, on one clock. While nrst=0: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. busy=CLEAR_ON_RESET. The FSM goes to CLEAR if CLEAR_ON_RESET, else READY. The clear pointer resets to 0.
- FSM states are CLEAR and READY.
- CLEAR: each cycle writes zero to the BYTES_PER_WORD bytes at clr_ptr, then advances clr_ptr by BYTES_PER_WORD. This takes exactly MEM_DEPTH/BYTES_PER_WORD cycles (1024 at defaults). After the last word, go to READY and drop busy. req_ready=0 throughout; requests are ignored, not queued.
- READY: req_ready=1 every cycle. A request is accepted when req_valid & req_ready at a rising edge.
- Range check: the access is in range iff req_addr + BYTES_PER_WORD - 1 <= MEM_DEPTH-1, computed at ADDR_WIDTH+1 bits so it cannot wrap. An out-of-range access modifies no byte, gives rsp_err=1 and rsp_rdata=0. There is no partial access and no address wrap.
- Write: on the accept edge, each byte i with req_be bit set is updated; unset bytes are unchanged. The next cycle gives rsp_valid=1, rsp_err=0, rsp_rdata=0. req_be=0 is a legal no-op that still responds.
- Read: the array is sampled at the accept edge and the result registered. rsp_valid rises the following cycle, so latency is 1 and throughput is one request per cycle. req_be is ignored on reads.
- Read after write: a read accepted on the cycle after a write returns the written data, since the write commits at its accept edge.
- The response has no backpressure; the consumer must take rsp_* in the rsp_valid cycle. rsp_valid deasserts in any cycle with no accepted request on the prior edge, and rsp_rdata/rsp_err return to 0 then.
- Reset asserted mid-operation: a pending response is dropped and no partial write occurs beyond bytes already committed on earlier edges. If CLEAR_ON_RESET=1, the full clear re-runs.
- MEM_DEPTH not a multiple of BYTES_PER_WORD, or MEM_DEPTH > 2**ADDR_WIDTH, is a parameter error flagged at elaboration.

Test Plan:
- Defaults, CLEAR_ON_RESET=1; release nrst -> busy=1 and req_ready=0 for exactly 1024 cycles, then req_ready=1. A read at 0x248 returns rsp_rdata=0x0000 with rsp_err=0.
- Write 0x648 data 0xB000 be=11; next cycle read 0x648 -> the cycle after, rsp_valid=1 and rsp_rdata=0xB000. Byte 0x648=0xB0, 0x649=0x00.
- Write 0x008 data 0x1234 be=11, then write 0x008 data 0xABCD be=01; read 0x008 -> 0x12CD. Then read unaligned 0x009 -> 0xCD00.
- Read 0x7FF at defaults -> rsp_valid=1, rsp_err=1, rsp_rdata=0. Write 0x7FF data 0xFFFF -> rsp_err=1 and byte 0x7FF unchanged (0x00).
- Back-to-back reads at 0x688, 0x68A, 0x68E on three consecutive cycles after writes of 5, 4, 3 -> rsp_valid high three consecutive cycles with 0x0005, 0x0004, 0x0003 in order.
- BYTES_PER_WORD=4, CLEAR_ON_RESET=0: write 0x010 data 0xDEADBEEF be=1010, then reset mid-stream and read 0x010 -> 0xDE00BE00 (contents retained, no clear).
